sa_port_arbiter: RTL and testbench



---
 rtl/sa_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/sa_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sa_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_arb_pkg.sv
// Shared types and constants for the sense-amplifier read-port arbiter.
// Contents:
//   sa_state_e - sequencer states (IDLE, ARB, ISSUE, WAIT_FIN, RESP)
//   DefAddrW   - default decoder address width
//   DefDataW   - default sense-amplifier data width
//   id_width() - bits needed to index n requesters (minimum 1)
package sa_arb_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StArb     = 3'd1,
      StIssue   = 3'd2,
      StWaitFin = 3'd3,
      StResp    = 3'd4
   } sa_state_e;

   localparam int unsigned DefAddrW = 21;
   localparam int unsigned DefDataW = 9;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// The search starts just above the last granted index and wraps around.
// The same picker is intended for the write-port arbiter.
// Ports:
//   req_i    - request vector
//   last_i   - index granted most recently
//   valid_o  - at least one request is pending
//   winner_o - index of the selected requester
module rr_arbiter import sa_arb_pkg::*; #(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdW    = id_width(NumReq)
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdW-1:0]    last_i,
   output logic              valid_o,
   output logic [IdW-1:0]    winner_o
);

   int unsigned idx;

   always_comb begin
      valid_o  = 1'b0;
      winner_o = '0;
      idx      = 0;
      for (int unsigned i = 1; i <= NumReq; i++) begin
         idx = (32'(last_i) + i) % NumReq;
         if (!valid_o && req_i[idx]) begin
            valid_o  = 1'b1;
            winner_o = IdW'(idx);
         end
      end
   end

endmodule

// File: rtl/sa_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared array read port.
// The arbiter grants one requester and drives the decoder address with sa_en_o.
// It then waits for read_finish_i, captures sa_out_i and returns the data
// together with a one-cycle ack.
// All outputs are decoded from registered state.
// Optional build macro SA_TIMEOUT_EN adds a WAIT_FIN watchdog (TIMEOUT_CYC) and err_o.
// Ports:
//   sys_clk, rst_n  - clock, asynchronous active-low reset
//   sys_en_i        - low blocks new arbitration
//   req_i           - per-requester level request, held until ack
//   req_addr_i      - packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_mode_i      - per-requester mode, 1 forces captured data LSB to 0
//   read_finish_i   - SA conversion done
//   sa_out_i        - SA data
//   sa_en_o         - SA enable (ISSUE, WAIT_FIN)
//   address_o       - decoder address, holds its last value
//   ack_o           - one-hot completion pulse
//   rdata_o         - read data, valid with ack_o
//   grant_id_o      - current or last granted requester
//   busy_o          - high outside IDLE
//   err_o           - watchdog timeout, pulses with ack_o (SA_TIMEOUT_EN only)
module sa_port_arbiter import sa_arb_pkg::*; #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned DATA_W  = DefDataW,
   localparam int unsigned IdW    = id_width(NUM_REQ)
`ifdef SA_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
   input  logic                      sys_clk,
   input  logic                      rst_n,
   input  logic                      sys_en_i,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ-1:0]        req_mode_i,
   input  logic                      read_finish_i,
   input  logic [DATA_W-1:0]         sa_out_i,
   output logic                      sa_en_o,
   output logic [ADDR_W-1:0]         address_o,
   output logic [NUM_REQ-1:0]        ack_o,
   output logic [DATA_W-1:0]         rdata_o,
   output logic [IdW-1:0]            grant_id_o,
   output logic                      busy_o
`ifdef SA_TIMEOUT_EN
   , output logic                    err_o
`endif
);

   sa_state_e           state_q, state_d;
   logic [IdW-1:0]      last_grant_q, last_grant_d;
   logic [IdW-1:0]      grant_id_q, grant_id_d;
   logic                sel_vld_q, sel_vld_d;
   logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                mode_q, mode_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                arb_valid;
   logic [IdW-1:0]      arb_winner;
   logic [ADDR_W-1:0]   win_addr;
   logic [ADDR_W-1:0]   issue_addr;
   logic                timeout_hit;

   rr_arbiter #(
      .NumReq (NUM_REQ),
      .IdW    (IdW)
   ) u_rr_arbiter (
      .req_i    (req_i),
      .last_i   (last_grant_q),
      .valid_o  (arb_valid),
      .winner_o (arb_winner)
   );

   assign win_addr = req_addr_i[32'(arb_winner) * ADDR_W +: ADDR_W];
   // The selection is made in the first ARB cycle and then frozen while read_finish is high.
   assign issue_addr = sel_vld_q ? lat_addr_q : win_addr;

`ifdef SA_TIMEOUT_EN
   localparam int unsigned CntW = id_width(TIMEOUT_CYC);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            to_q, to_d;

   assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      to_d  = to_q;
      if (state_q == StArb && state_d == StIssue) begin
         cnt_d = '0;
         to_d  = 1'b0;
      end else if (state_q == StWaitFin) begin
         cnt_d = cnt_q + 1'b1;
         if (!read_finish_i && timeout_hit) to_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign err_o = (state_q == StResp) && to_q;
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      sel_vld_d    = sel_vld_q;
      lat_addr_d   = lat_addr_q;
      addr_d       = addr_q;
      mode_d       = mode_q;
      rdata_d      = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (sys_en_i && |req_i) state_d = StArb;
         end
         StArb: begin
            if (!sel_vld_q) begin
               if (arb_valid) begin
                  sel_vld_d  = 1'b1;
                  grant_id_d = arb_winner;
                  lat_addr_d = win_addr;
                  mode_d     = req_mode_i[arb_winner];
               end else begin
                  // Every requester withdrew before selection.
                  state_d = StIdle;
               end
            end
            if ((sel_vld_q || arb_valid) && !read_finish_i) begin
               state_d   = StIssue;
               addr_d    = issue_addr;
               sel_vld_d = 1'b0;
            end
         end
         StIssue: begin
            state_d = StWaitFin;
         end
         StWaitFin: begin
            if (read_finish_i) begin
               rdata_d = mode_q ? {sa_out_i[DATA_W-1:1], 1'b0} : sa_out_i;
               state_d = StResp;
            end else if (timeout_hit) begin
               rdata_d = '0;
               state_d = StResp;
            end
         end
         StResp: begin
            last_grant_d = grant_id_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= IdW'(NUM_REQ - 1);
         grant_id_q   <= '0;
         sel_vld_q    <= 1'b0;
         lat_addr_q   <= '0;
         addr_q       <= '0;
         mode_q       <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         sel_vld_q    <= sel_vld_d;
         lat_addr_q   <= lat_addr_d;
         addr_q       <= addr_d;
         mode_q       <= mode_d;
         rdata_q      <= rdata_d;
      end
   end

   assign sa_en_o    = (state_q == StIssue) || (state_q == StWaitFin);
   assign address_o  = addr_q;
   assign ack_o      = (state_q == StResp) ? (NUM_REQ'(1) << grant_id_q) : '0;
   assign rdata_o    = rdata_q;
   assign grant_id_o = grant_id_q;
   assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_sa_port_arbiter.sv
// Directed bench for sa_port_arbiter with the default configuration (2 requesters).
// With SA_TIMEOUT_EN defined, the watchdog is built with TIMEOUT_CYC=8 and is exercised.
module tb_sa_port_arbiter;

   logic        sys_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sys_en = 1'b0;
   logic [1:0]  req = '0;
   logic [41:0] req_addr = '0;
   logic [1:0]  req_mode = '0;
   logic        rf = 1'b0;
   logic [8:0]  sa_out = '0;
   logic        sa_en;
   logic [20:0] address;
   logic [1:0]  ack;
   logic [8:0]  rdata;
   logic [0:0]  grant_id;
   logic        busy;
`ifdef SA_TIMEOUT_EN
   logic        err;
`endif

   int checks = 0;
   int failures = 0;

   always #5 sys_clk = ~sys_clk;

   sa_port_arbiter #(
      .NUM_REQ (2),
      .ADDR_W  (21),
      .DATA_W  (9)
`ifdef SA_TIMEOUT_EN
      , .TIMEOUT_CYC (8)
`endif
   ) dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .sys_en_i      (sys_en),
      .req_i         (req),
      .req_addr_i    (req_addr),
      .req_mode_i    (req_mode),
      .read_finish_i (rf),
      .sa_out_i      (sa_out),
      .sa_en_o       (sa_en),
      .address_o     (address),
      .ack_o         (ack),
      .rdata_o       (rdata),
      .grant_id_o    (grant_id),
      .busy_o        (busy)
`ifdef SA_TIMEOUT_EN
      , .err_o       (err)
`endif
   );

   task automatic set_addr(input int i, input logic [20:0] a);
      req_addr[i*21 +: 21] = a;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      checks++; if (sa_en !== 1'b0) begin failures++; $display("FAIL rst_sa_en got=%b exp=0", sa_en); end
      checks++; if (address !== 21'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", address); end
      checks++; if (ack !== 2'b00) begin failures++; $display("FAIL rst_ack got=%b exp=00", ack); end
      checks++; if (rdata !== 9'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
      checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL rst_gid got=%b exp=0", grant_id); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
`ifdef SA_TIMEOUT_EN
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
`endif
      rst_n = 1'b1;
      @(negedge sys_clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_en busy=%b exp=0", busy); end
   endtask

   task automatic test_single();
      sys_en = 1'b1; set_addr(0, 21'h00080); req_mode = 2'b00; sa_out = 9'h1A5; req = 2'b01;
      @(negedge sys_clk);  // ARB
      checks++; if (busy !== 1'b1 || sa_en !== 1'b0) begin
         failures++; $display("FAIL single_arb busy=%b sa_en=%b exp 1/0", busy, sa_en); end
      @(negedge sys_clk);  // ISSUE
      checks++; if (sa_en !== 1'b1 || address !== 21'h00080) begin
         failures++; $display("FAIL single_issue sa_en=%b addr=%h exp 1/00080", sa_en, address); end
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);  // WAIT_FIN
         checks++; if (sa_en !== 1'b1 || address !== 21'h00080 || ack !== 2'b00) begin
            failures++;
            $display("FAIL single_wait sa_en=%b addr=%h ack=%b exp 1/00080/00", sa_en, address, ack);
         end
         if (i == 2) rf = 1'b1;
      end
      @(negedge sys_clk);  // RESP
      checks++; if (ack !== 2'b01 || rdata !== 9'h1A5 || sa_en !== 1'b0) begin
         failures++; $display("FAIL single_resp ack=%b rdata=%h sa_en=%b exp 01/1a5/0", ack, rdata, sa_en);
      end
      rf = 1'b0; req = 2'b00;
      @(negedge sys_clk);  // IDLE
      checks++; if (ack !== 2'b00 || busy !== 1'b0 || rdata !== 9'h1A5 || address !== 21'h00080) begin
         failures++;
         $display("FAIL single_after ack=%b busy=%b rdata=%h addr=%h exp 00/0/1a5/00080",
                  ack, busy, rdata, address);
      end
   endtask

   task automatic test_mode();
      req_mode = 2'b10; set_addr(1, 21'h1ABCD); sa_out = 9'h1FF; req = 2'b10;
      @(negedge sys_clk);  // ARB
      @(negedge sys_clk);  // ISSUE
      checks++; if (address !== 21'h1ABCD || grant_id !== 1'b1) begin
         failures++; $display("FAIL mode_issue addr=%h gid=%b exp 1abcd/1", address, grant_id); end
      @(negedge sys_clk);  // WAIT_FIN
      rf = 1'b1;
      @(negedge sys_clk);  // RESP
      checks++; if (ack !== 2'b10 || rdata !== 9'h1FE) begin
         failures++; $display("FAIL mode_resp ack=%b rdata=%h exp 10/1fe", ack, rdata); end
      rf = 1'b0; req = 2'b00; req_mode = 2'b00;
      @(negedge sys_clk);
   endtask

   task automatic test_contention();
      int          n = 0;
      logic [20:0] seen_addr = '0;
      logic [1:0]  exp_ack;
      logic [20:0] exp_addr;
      set_addr(0, 21'h00011); set_addr(1, 21'h10022); sa_out = 9'h0C0; req = 2'b11;
      for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
         @(negedge sys_clk);
         rf = sa_en;
         if (sa_en) seen_addr = address;
         if (ack !== 2'b00) begin
            exp_ack  = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (n % 2 == 0) ? 21'h00011 : 21'h10022;
            checks++; if (ack !== exp_ack || grant_id !== exp_ack[1]) begin
               failures++;
               $display("FAIL cont_order n=%0d ack=%b gid=%b exp_ack=%b", n, ack, grant_id, exp_ack);
            end
            checks++; if (rdata !== 9'h0C0 + 9'(n) || seen_addr !== exp_addr) begin
               failures++;
               $display("FAIL cont_data n=%0d rdata=%h addr=%h exp %h/%h", n, rdata, seen_addr,
                        9'h0C0 + 9'(n), exp_addr);
            end
            n++;
            sa_out = 9'h0C0 + 9'(n);
            if (n == 4) req = 2'b00;
         end
      end
      checks++; if (n != 4) begin failures++; $display("FAIL cont_timeout acks=%0d exp=4", n); end
      req = 2'b00; rf = 1'b0;
      @(negedge sys_clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_idle busy=%b exp=0", busy); end
   endtask

   task automatic test_finish_held();
      set_addr(0, 21'h0ABCD); sa_out = 9'h033; rf = 1'b1; req = 2'b01;
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clk);  // ARB, held by read_finish
         checks++; if (sa_en !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL held_arb i=%0d sa_en=%b busy=%b exp 0/1", i, sa_en, busy); end
         if (i == 1) req = 2'b10;  // requester 0 drops after the selection is latched
         if (i == 4) rf = 1'b0;
      end
      @(negedge sys_clk);  // ISSUE
      checks++; if (sa_en !== 1'b1 || grant_id !== 1'b0 || address !== 21'h0ABCD) begin
         failures++;
         $display("FAIL held_issue sa_en=%b gid=%b addr=%h exp 1/0/0abcd", sa_en, grant_id, address);
      end
      req = 2'b00;
      @(negedge sys_clk);  // WAIT_FIN
      rf = 1'b1;
      @(negedge sys_clk);  // RESP
      checks++; if (ack !== 2'b01 || rdata !== 9'h033) begin
         failures++; $display("FAIL held_resp ack=%b rdata=%h exp 01/033", ack, rdata); end
      rf = 1'b0;
      @(negedge sys_clk);
   endtask

   task automatic test_drop_before_arb();
      // Round-robin order would pick requester 1 next, but it withdraws during ARB.
      sa_out = 9'h155; req = 2'b11;
      @(negedge sys_clk);  // ARB
      req = 2'b01;
      @(negedge sys_clk);  // ISSUE
      checks++; if (grant_id !== 1'b0 || sa_en !== 1'b1) begin
         failures++; $display("FAIL drop_gid gid=%b sa_en=%b exp 0/1", grant_id, sa_en); end
      rf = 1'b1;
      @(negedge sys_clk);  // WAIT_FIN
      @(negedge sys_clk);  // RESP
      checks++; if (ack !== 2'b01 || rdata !== 9'h155) begin
         failures++; $display("FAIL drop_resp ack=%b rdata=%h exp 01/155", ack, rdata); end
      rf = 1'b0; req = 2'b00;
      @(negedge sys_clk);
   endtask

   task automatic test_sysen_drop();
      sa_out = 9'h0F0; req = 2'b01; sys_en = 1'b1;
      @(negedge sys_clk);  // ARB
      @(negedge sys_clk);  // ISSUE
      @(negedge sys_clk);  // WAIT_FIN
      sys_en = 1'b0;
      @(negedge sys_clk);
      checks++; if (sa_en !== 1'b1) begin failures++; $display("FAIL en_wait sa_en=%b exp=1", sa_en); end
      rf = 1'b1;
      @(negedge sys_clk);  // RESP
      checks++; if (ack !== 2'b01 || rdata !== 9'h0F0) begin
         failures++; $display("FAIL en_resp ack=%b rdata=%h exp 01/0f0", ack, rdata); end
      rf = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge sys_clk);
         checks++; if (sa_en !== 1'b0 || busy !== 1'b0 || ack !== 2'b00) begin
            failures++;
            $display("FAIL en_blocked i=%0d sa_en=%b busy=%b ack=%b exp 0/0/00", i, sa_en, busy, ack);
         end
      end
      req = 2'b00; sys_en = 1'b1;
   endtask

`ifdef SA_TIMEOUT_EN
   task automatic test_timeout();
      req = 2'b01; rf = 1'b0;
      @(negedge sys_clk);  // ARB
      @(negedge sys_clk);  // ISSUE
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clk);  // WAIT_FIN
         checks++; if (ack !== 2'b00 || err !== 1'b0 || sa_en !== 1'b1) begin
            failures++;
            $display("FAIL to_wait i=%0d ack=%b err=%b sa_en=%b exp 00/0/1", i, ack, err, sa_en);
         end
      end
      @(negedge sys_clk);  // RESP
      checks++; if (ack !== 2'b01 || err !== 1'b1 || rdata !== 9'h0) begin
         failures++; $display("FAIL to_resp ack=%b err=%b rdata=%h exp 01/1/000", ack, err, rdata); end
      req = 2'b00;
      @(negedge sys_clk);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_clear err=%b exp=0", err); end
   endtask
`endif

   task automatic test_reset_mid();
      req = 2'b01; rf = 1'b0; sa_out = 9'h0AA;
      @(negedge sys_clk);  // ARB
      @(negedge sys_clk);  // ISSUE
      checks++; if (sa_en !== 1'b1) begin failures++; $display("FAIL rmid_pre sa_en=%b exp=1", sa_en); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (sa_en !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL rmid_async sa_en=%b busy=%b exp 0/0", sa_en, busy); end
      req = 2'b00; rf = 1'b1;
      @(negedge sys_clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         checks++; if (ack !== 2'b00 || busy !== 1'b0 || rdata !== 9'h0) begin
            failures++;
            $display("FAIL rmid_after i=%0d ack=%b busy=%b rdata=%h exp 00/0/000", i, ack, busy, rdata);
         end
      end
      rf = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_mode();
      test_contention();
      test_finish_held();
      test_drop_before_arb();
      test_sysen_drop();
`ifdef SA_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
